// File: rtl/posit_result_checker.sv
// Latency-aligned posit result checker: delays expected values, compares, tallies stats.
// Optional CHECKER_HALT_ON_ERR_EN: first mismatch ends the session early.
module posit_result_checker #(
  parameter int N       = 8,
  parameter int LATENCY = 6,
  parameter int TOL     = 0,
  parameter int CW      = 32
) (
  input  logic          aclk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [N-1:0]  in1,
  input  logic [N-1:0]  in2,
  input  logic [N-1:0]  expected,
  input  logic [N-1:0]  dut_result,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] total_count,
  output logic [CW-1:0] err_count,
  output logic [N-1:0]  max_diff,
  output logic          first_err_valid,
  output logic [N-1:0]  first_err_in1,
  output logic [N-1:0]  first_err_in2,
  output logic [N-1:0]  first_err_out,
  output logic [N-1:0]  first_err_exp
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [N-1:0] NAR   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] TOL_V = N'(TOL);
  localparam logic [6:0]   LAST  = 7'(LATENCY - 1);

  state_t          state_q;
  logic [6:0]      cnt_q;
  logic            vld_q [LATENCY];
  logic [N-1:0]    a_q   [LATENCY];
  logic [N-1:0]    b_q   [LATENCY];
  logic [N-1:0]    e_q   [LATENCY];
  logic [CW-1:0]   total_q, err_q;
  logic [N-1:0]    max_q, fa_q, fb_q, fo_q, fe_q;
  logic            fev_q;

  logic            shift, enter_run, tail_v, mism, err_en, halt;
  logic [N-1:0]    tail_e, diff;

  assign shift     = (state_q == RUN) || (state_q == DRAIN);
  assign enter_run = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign tail_v    = shift && vld_q[LATENCY-1];
  assign tail_e    = e_q[LATENCY-1];

  // NaR only matches NaR; any NaR mismatch reports the worst possible diff
  always_comb begin
    diff = '0;
    if (tail_e == NAR || dut_result == NAR)
      diff = (tail_e == dut_result) ? '0 : '1;
    else if (tail_e >= dut_result)
      diff = tail_e - dut_result;
    else
      diff = dut_result - tail_e;
  end

  assign mism = tail_v && (diff > TOL_V);

`ifdef CHECKER_HALT_ON_ERR_EN
  assign err_en = mism && !fev_q;
  assign halt   = mism && !fev_q && (state_q == RUN);
`else
  assign err_en = mism;
  assign halt   = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (shift) begin
      a_q[0] <= in1;
      b_q[0] <= in2;
      e_q[0] <= expected;
      for (int i = 1; i < LATENCY; i++) begin
        a_q[i] <= a_q[i-1];
        b_q[i] <= b_q[i-1];
        e_q[i] <= e_q[i-1];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) vld_q[i] <= 1'b0;
    end else if (shift) begin
      vld_q[0] <= in_valid && (state_q == RUN);
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end else if (enter_run) begin
      for (int i = 0; i < LATENCY; i++) vld_q[i] <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      total_q <= '0;
      err_q   <= '0;
      max_q   <= '0;
      fev_q   <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      fo_q    <= '0;
      fe_q    <= '0;
    end else begin
      if (tail_v) begin
        if (total_q != '1) total_q <= total_q + CW'(1);
        if (err_en && err_q != '1) err_q <= err_q + CW'(1);
        if (diff > max_q) max_q <= diff;
        if (mism && !fev_q) begin
          fev_q <= 1'b1;
          fa_q  <= a_q[LATENCY-1];
          fb_q  <= b_q[LATENCY-1];
          fo_q  <= dut_result;
          fe_q  <= tail_e;
        end
      end
      if (enter_run) begin
        total_q <= '0;
        err_q   <= '0;
        max_q   <= '0;
        fev_q   <= 1'b0;
        fa_q    <= '0;
        fb_q    <= '0;
        fo_q    <= '0;
        fe_q    <= '0;
      end
      unique case (state_q)
        IDLE:  if (start) state_q <= RUN;
        RUN: begin
          if (!start || halt) begin
            state_q <= DRAIN;
            cnt_q   <= '0;
          end
        end
        DRAIN: begin
          if (cnt_q == LAST) state_q <= DONE;
          else cnt_q <= cnt_q + 7'd1;
        end
        DONE:  if (start) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = shift;
  assign done            = (state_q == DONE);
  assign total_count     = total_q;
  assign err_count       = err_q;
  assign max_diff        = max_q;
  assign first_err_valid = fev_q;
  assign first_err_in1   = fa_q;
  assign first_err_in2   = fb_q;
  assign first_err_out   = fo_q;
  assign first_err_exp   = fe_q;

endmodule

// File: tb/tb_posit_result_checker.sv
// Bench for posit_result_checker: two instances (TOL 0 and 3) fed the same stream,
// checked against a list-based model of accepted vectors.
module tb_posit_result_checker;

  localparam int N   = 8;
  localparam int LAT = 6;
  localparam int CW  = 32;

  logic aclk = 1'b0;
  logic reset, start, in_valid;
  logic [N-1:0] in1, in2, expected, dut_result;

  logic          busy0, done0, fev0, busy3, done3, fev3;
  logic [CW-1:0] tc0, ec0, tc3, ec3;
  logic [N-1:0]  md0, fa0, fb0, fo0, fe0;
  logic [N-1:0]  md3, fa3, fb3, fo3, fe3;

  posit_result_checker #(.N(N), .LATENCY(LAT), .TOL(0), .CW(CW)) u0 (
    .aclk(aclk), .reset(reset), .start(start), .in_valid(in_valid),
    .in1(in1), .in2(in2), .expected(expected), .dut_result(dut_result),
    .busy(busy0), .done(done0), .total_count(tc0), .err_count(ec0),
    .max_diff(md0), .first_err_valid(fev0), .first_err_in1(fa0),
    .first_err_in2(fb0), .first_err_out(fo0), .first_err_exp(fe0)
  );

  posit_result_checker #(.N(N), .LATENCY(LAT), .TOL(3), .CW(CW)) u3 (
    .aclk(aclk), .reset(reset), .start(start), .in_valid(in_valid),
    .in1(in1), .in2(in2), .expected(expected), .dut_result(dut_result),
    .busy(busy3), .done(done3), .total_count(tc3), .err_count(ec3),
    .max_diff(md3), .first_err_valid(fev3), .first_err_in1(fa3),
    .first_err_in2(fb3), .first_err_out(fo3), .first_err_exp(fe3)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [N-1:0] a, b, e, r;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t acc[$];
  logic         vv [256];
  logic [N-1:0] va [256];
  logic [N-1:0] vb [256];
  logic [N-1:0] ve [256];
  logic [N-1:0] vr [256];

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pdiff(input logic [N-1:0] e, input logic [N-1:0] r);
    int ie = int'(e);
    int ir = int'(r);
    if (ie == 128 || ir == 128) return (ie == ir) ? 0 : 255;
    return (ie > ir) ? ie - ir : ir - ie;
  endfunction

  task automatic model_check(input string tag, input int tol,
                             input logic [CW-1:0] tc, input logic [CW-1:0] ec,
                             input logic [N-1:0] md, input logic fev,
                             input logic [N-1:0] fa, input logic [N-1:0] fb,
                             input logic [N-1:0] fo, input logic [N-1:0] fe);
    int   t = 0, e = 0, m = 0;
    bit   got = 0;
    vec_t fv = '{a: '0, b: '0, e: '0, r: '0};
    foreach (acc[i]) begin
      int d = pdiff(acc[i].e, acc[i].r);
      t++;
      if (d > m) m = d;
      if (d > tol) begin
        e++;
        if (!got) begin
          got = 1;
          fv  = acc[i];
        end
      end
    end
    chk({tag, " total"}, tc, 32'(t));
    chk({tag, " errs"}, ec, 32'(e));
    chk({tag, " maxd"}, 32'(md), 32'(m));
    chk({tag, " fev"}, 32'(fev), 32'(got));
    chk({tag, " fin1"}, 32'(fa), 32'(fv.a));
    chk({tag, " fin2"}, 32'(fb), 32'(fv.b));
    chk({tag, " fout"}, 32'(fo), 32'(fv.r));
    chk({tag, " fexp"}, 32'(fe), 32'(fv.e));
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, " busy"}, 32'({busy0, busy3}), 32'(0));
    chk({tag, " done"}, 32'({done0, done3}), 32'(0));
    chk({tag, " tc"}, tc0 | tc3, 32'(0));
    chk({tag, " ec"}, ec0 | ec3, 32'(0));
    chk({tag, " md"}, 32'(md0 | md3), 32'(0));
    chk({tag, " fev"}, 32'({fev0, fev3}), 32'(0));
    chk({tag, " fvec"}, {fa0 | fa3, fb0 | fb3, fo0 | fo3, fe0 | fe3}, 32'(0));
  endtask

  // mode 0: clean, 1: corrupt vector 17, 2: gap pattern with random corruption
  task automatic build(input int mode, input int k);
    bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < k; i++) begin
      vv[i] = (mode == 2) ? pat[i % 5] : 1'b1;
      va[i] = N'($urandom);
      vb[i] = N'($urandom);
      ve[i] = N'($urandom);
      vr[i] = ve[i];
      if (mode == 2 && $urandom_range(0, 3) == 0)
        vr[i] = ve[i] + N'($urandom_range(1, 5));
    end
    if (mode == 1) begin
      ve[17] = 8'h40;
      vr[17] = 8'h43;
    end
    if (mode == 2) begin
      ve[2] = 8'h80;
      vr[2] = 8'h7F;
      ve[3] = 8'h80;
      vr[3] = 8'h80;
    end
  endtask

  task automatic run_session(input string tag, input int k);
    acc.delete();
    start    = 1'b1;
    in_valid = 1'b0;
    step();
    chk({tag, " run busy"}, 32'({busy0, done0}), 32'(2));
    for (int c = 0; c <= k + LAT; c++) begin
      if (c < k) begin
        start    = 1'b1;
        in_valid = vv[c];
        in1      = va[c];
        in2      = vb[c];
        expected = ve[c];
        if (vv[c]) acc.push_back('{a: va[c], b: vb[c], e: ve[c], r: vr[c]});
      end else begin
        start    = 1'b0;
        in_valid = 1'b0;
        in1      = N'($urandom);
        in2      = N'($urandom);
        expected = N'($urandom);
      end
      if (c >= LAT && c - LAT < k && vv[c-LAT]) dut_result = vr[c-LAT];
      else dut_result = N'($urandom);
      step();
      if (c >= k) begin
        chk($sformatf("%s done@%0d", tag, c - k), 32'(done0), 32'(c == k + LAT));
        chk($sformatf("%s busy@%0d", tag, c - k), 32'(busy0), 32'(c != k + LAT));
      end
    end
    model_check({tag, " t0"}, 0, tc0, ec0, md0, fev0, fa0, fb0, fo0, fe0);
    model_check({tag, " t3"}, 3, tc3, ec3, md3, fev3, fa3, fb3, fo3, fe3);
    in_valid   = 1'b1;
    dut_result = N'($urandom);
    step();
    chk({tag, " hold done"}, 32'(done0 & done3), 32'(1));
    model_check({tag, " hold"}, 0, tc0, ec0, md0, fev0, fa0, fb0, fo0, fe0);
    in_valid = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in1        = '0;
    in2        = '0;
    expected   = '0;
    dut_result = '0;
    step();
    step();
    reset = 1'b0;
    step();
    zero_chk("reset");

    build(0, 100);
    run_session("clean", 100);

    build(1, 100);
    run_session("corrupt17", 100);

    build(2, 50);
    run_session("gap", 50);

    start = 1'b1;
    step();
    for (int c = 0; c < 20; c++) begin
      in_valid   = 1'b1;
      in1        = N'($urandom);
      in2        = N'($urandom);
      expected   = N'($urandom);
      dut_result = N'($urandom);
      step();
    end
    reset = 1'b1;
    step();
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    zero_chk("midreset");
    step();
    zero_chk("idle");

    build(2, 40);
    run_session("restart", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_result_checker.md
Name: posit_result_checker

Overview:
- Synthesizable, latency-aligned result checker for the posit arithmetic units (posit_adder and siblings); the response side of the operand stimulus stream.
- Accepts the operand/expected-result stream in step with the DUT inputs and delays it by the DUT pipeline latency.
- Compares the delayed expected value against the DUT result and accumulates sample, error and max-difference statistics; captures the first failing vector.
- Used in on-chip self-test and in regression benches in place of file-based comparison.

Parameters:
- N, 8, posit width in bits
- LATENCY, 6, DUT cycles from operand presentation to valid result (1..64)
- TOL, 0, maximum accepted unsigned bit-pattern difference (in ULP-of-encoding)
- CW, 32, statistics counter width

Ports:
- aclk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  level; high = run session, falling edge begins drain
- in_valid  in  1  operand/expected triple valid this cycle (same cycle the DUT sees in1/in2)
- in1  in  N  operand 1 as presented to DUT
- in2  in  N  operand 2 as presented to DUT
- expected  in  N  golden result for in1/in2
- dut_result  in  N  DUT result output
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- total_count  out  CW  compared samples
- err_count  out  CW  samples with diff > TOL
- max_diff  out  N  largest diff observed
- first_err_valid  out  1  a mismatch has been captured
- first_err_in1 / first_err_in2 / first_err_out / first_err_exp  out  N each  first failing vector

Behaviour:
- Reset: state IDLE; all outputs 0; delay-line valid bits cleared. Reset mid-session aborts; no partial statistics retained.
- FSM: IDLE -> RUN when start=1 (on entry: counters, max_diff, first_err_* cleared; delay line flushed). RUN -> DRAIN when start=0. DRAIN -> DONE after exactly LATENCY cycles. DONE -> RUN when start=1 (same clearing); otherwise holds.
- Delay line: LATENCY-deep shift register of {valid, in1, in2, expected}; shifts every cycle in RUN and DRAIN; pushed valid = in_valid & (state==RUN). In DRAIN a 0 valid is shifted in. In_valid outside RUN is ignored.
- Alignment: triple accepted at edge t is compared against dut_result sampled at edge t+LATENCY.
- diff = |expected - dut_result| as unsigned N-bit; no wrap (larger minus smaller).
- NaR rule: if either expected or dut_result equals NaR (1 followed by N-1 zeros), match iff both are NaR; on NaR mismatch diff is forced to all-ones.
- Mismatch = diff > TOL. Statistics registered at the compare edge: total_count+1; err_count+1 on mismatch; max_diff = max(max_diff, diff).
- Counters saturate at 2^CW-1; no wrap.
- First error: on first mismatch of a session, latch the four vectors, set first_err_valid; later mismatches do not overwrite.
- Statistics frozen in IDLE and DONE; outputs stay readable in DONE.
- start toggling 1->0->1 within DRAIN: DRAIN completes, DONE lasts at least one cycle, then re-enters RUN.

Optional Feature:
- Macro CHECKER_HALT_ON_ERR_EN.
- Defined: first mismatch forces an immediate jump to DRAIN regardless of start; the delay line is then flushed and no further mismatches counted beyond the first (total_count still counts drained samples).
- Undefined: session runs until start falls; all mismatches counted.

Test Plan:
- N=8, LATENCY=6, TOL=0; 100 vectors with dut_result = expected delayed 6 cycles -> done, total_count=100, err_count=0, max_diff=0, first_err_valid=0.
- Corrupt vector #17 (expected 8'h40, dut 8'h43) -> err_count=1, max_diff=3, first_err_exp=8'h40, first_err_out=8'h43, in1/in2 of vector #17 latched.
- TOL=3, same corruption -> err_count=0, max_diff=3; expected 8'h80 vs dut 8'h7F -> err_count=1, max_diff=8'hFF.
- Gap pattern: in_valid 1,0,1,1,0 over 50 cycles, start dropped -> DONE exactly 6 cycles after start falls; total_count = number of in_valid pulses.
- Assert reset at cycle 20 of RUN -> next cycle IDLE, all outputs 0; restart gives fresh counts.
- With CHECKER_HALT_ON_ERR_EN, two mismatches at #5 and #9 -> err_count=1, DONE within 7 cycles of #5 comparison with start still high.
